uart_loader: RTL and testbench
==============================

// Module: uart_loader
// PURPOSE
//  Command sequencer behind the UART receiver (rx_byte/rx_ready strobe stream @460800 baud).
//  Parses framed packets from the host and turns them into byte writes to PRG/CHR memory.
//  Holds the NES CPU while loading and releases it on command.
//  Reports per-packet completion or error to status logic/LEDs.
// PARAMETERS
//  ADDR_W     16        memory address width; mem_addr wraps modulo 2^ADDR_W
//  SYNC_BYTE  8'hA5     packet start marker
//  TIMEOUT    24000     max clk12 cycles between bytes inside a packet (2 ms @12 MHz)
// PORTS
//  clk12     in   1       system clock, 12 MHz; only clock
//  rst_n     in   1       asynchronous, active-low reset
//  rx_byte   in   8       received byte, valid while rx_ready=1
//  rx_ready  in   1       one-cycle strobe: rx_byte holds a new byte
//  mem_addr  out  ADDR_W  write address
//  mem_data  out  8       write data
//  mem_we    out  1       one-cycle write strobe
//  cpu_hold  out  1       1 = keep CPU in reset
//  busy      out  1       1 = state != IDLE
//  done      out  1       one-cycle pulse: packet completed OK
//  err       out  1       one-cycle pulse: packet aborted
//  err_code  out  2       1 bad cmd, 2 checksum, 3 timeout; held until next err
// BEHAVIOUR
//  Reset: state IDLE; mem_addr=0, mem_data=0, mem_we=0, cpu_hold=1, done=0, err=0, err_code=0.
//  Packet: SYNC, CMD, then for WRITE: ADDR_L, ADDR_H, LEN, LEN data bytes, CSUM.
//   CMD 8'h01 WRITE; 8'h02 RUN (cpu_hold<=0); 8'h03 HOLD (cpu_hold<=1).
//   LEN 0 means 256 bytes; byte counter is 9 bits.
//   CSUM = XOR of CMD, ADDR_L, ADDR_H, LEN and all data bytes.
//  FSM (advances only on rx_ready): IDLE->CMD->ADDR_L->ADDR_H->LEN->DATA->CSUM->IDLE.
//   IDLE: byte==SYNC_BYTE -> CMD; other bytes ignored, no err.
//   CMD: WRITE -> ADDR_L and cpu_hold<=1 next cycle; RUN/HOLD -> apply, done pulse, IDLE;
//     other value -> err, err_code=1, IDLE.
//   LEN: -> DATA. Next address = {ADDR_H,ADDR_L}.
//   DATA: each byte: mem_data<=byte, mem_addr<=cur_addr, mem_we=1 the cycle after rx_ready;
//     cur_addr+1 (wraps); after last byte -> CSUM.
//   CSUM: match -> done pulse; mismatch -> err, err_code=2. Both -> IDLE.
//     Data already written is not rolled back.
//  done/err asserted the cycle after the rx_ready that ends the packet; never both.
//  Timeout: counter clears on every rx_ready and in IDLE; increments otherwise.
//   Reaching TIMEOUT in any state != IDLE -> err, err_code=3, IDLE.
//   rx_ready in the same cycle as terminal count: byte wins, no timeout.
//  SYNC_BYTE received in non-IDLE state is plain data (no resync).
//  cpu_hold changes only by reset, CMD WRITE/HOLD (->1) and RUN (->0); errors leave it.
//  rst_n low mid-packet: immediate return to reset values; partial writes stay in memory.
//  At most one mem_we per rx_ready; rx_ready spacing >=2 cycles, no internal buffering.
// TESTING
//  1 Reset release -> cpu_hold=1, busy=0, mem_we=0, err_code=0.
//  2 A5 01 00 80 02 12 34 A5 -> writes 12@8000, 34@8001, done pulse, err_code=0.
//  3 Same, last byte 00 -> same two writes, err pulse, err_code=2, state IDLE.
//  4 A5 01 FF FF 00 + 256 bytes 00..FF + correct CSUM -> 256 writes, addr FFFF then 0000..00FE.
//  5 A5 01 00 80 then silence > 24000 cycles -> err, err_code=3, no writes; A5 02 -> cpu_hold=0.
//  6 A5 07 -> err_code=1; 3C in IDLE ignored; rst_n low mid-DATA -> IDLE, cpu_hold=1.

Source files
------------

// File: rtl/uart_loader.sv
// uart_loader: packet sequencer between a UART receiver and PRG/CHR memory.
// It parses SYNC/CMD/ADDR/LEN/DATA/CSUM packets into byte writes, holds or
// releases the CPU on command, and reports per-packet done/err pulses.
//
// Handshake: rx_byte is sampled only in a cycle where rx_ready=1.
// rx_ready is a one-cycle strobe with no back-pressure, so every strobe is
// consumed in the cycle it arrives. Strobes are at least 2 cycles apart.
// mem_we is a one-cycle strobe with no ready; mem_addr/mem_data are valid
// while it is high and keep their last value afterwards.
module uart_loader #(
    parameter int          ADDR_W    = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 24000
) (
    input  logic              clk12,
    input  logic              rst_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    // Debug view of the FSM: 0 IDLE, 1 CMD, 2 ADDR_L, 3 ADDR_H, 4 LEN, 5 DATA, 6 CSUM
    output logic [2:0]        state_dbg
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] CMD_HOLD  = 8'h03;

    localparam logic [1:0] ERR_BAD_CMD  = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR_L = 3'd2,
        ADDR_H = 3'd3,
        LEN    = 3'd4,
        DATA   = 3'd5,
        CSUM   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [7:0]        addr_l_q, addr_l_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              timeout_hit;

    // State and datapath registers; async reset restores the power-up view.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            cur_addr_q <= '0;
            addr_l_q   <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            cur_addr_q <= cur_addr_d;
            addr_l_q   <= addr_l_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
        end
    end

    // A byte arriving on the terminal count wins over the timeout.
    assign timeout_hit = (state_q != IDLE) && !rx_ready && (tmo_q == TW'(TIMEOUT));

    // Next-state, packet parsing, write strobes, checksum and inter-byte timeout.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        cpu_hold_d = cpu_hold_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        cur_addr_d = cur_addr_q;
        addr_l_d   = addr_l_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;

        if (rx_ready || state_q == IDLE) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (timeout_hit) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = IDLE;
            tmo_d      = '0;
        end else if (rx_ready) begin
            case (state_q)
                IDLE: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = CMD;
                    end
                end
                CMD: begin
                    case (rx_byte)
                        CMD_WRITE: begin
                            cpu_hold_d = 1'b1;
                            csum_d     = rx_byte;
                            state_d    = ADDR_L;
                        end
                        CMD_RUN: begin
                            cpu_hold_d = 1'b0;
                            done_d     = 1'b1;
                            state_d    = IDLE;
                        end
                        CMD_HOLD: begin
                            cpu_hold_d = 1'b1;
                            done_d     = 1'b1;
                            state_d    = IDLE;
                        end
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_BAD_CMD;
                            state_d    = IDLE;
                        end
                    endcase
                end
                ADDR_L: begin
                    addr_l_d = rx_byte;
                    csum_d   = csum_q ^ rx_byte;
                    state_d  = ADDR_H;
                end
                ADDR_H: begin
                    cur_addr_d = ADDR_W'({rx_byte, addr_l_q});
                    csum_d     = csum_q ^ rx_byte;
                    state_d    = LEN;
                end
                LEN: begin
                    // A length byte of zero stands for a full 256-byte block.
                    cnt_d   = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                    csum_d  = csum_q ^ rx_byte;
                    state_d = DATA;
                end
                DATA: begin
                    mem_we_d   = 1'b1;
                    mem_data_d = rx_byte;
                    mem_addr_d = cur_addr_q;
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                    csum_d     = csum_q ^ rx_byte;
                    cnt_d      = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_d = CSUM;
                    end
                end
                CSUM: begin
                    // Bytes already written stay in memory on a bad checksum.
                    if (csum_q == rx_byte) begin
                        done_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHECKSUM;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_we    = mem_we_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: directed packets, a packet-level model of expected
// writes/outcomes/cpu_hold, and one per-cycle compare task.
module tb_uart_loader;

  logic        clk12 = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_ready = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [2:0]  state_dbg;

  uart_loader #(.ADDR_W(16), .SYNC_BYTE(8'hA5), .TIMEOUT(24000)) dut (
    .clk12(clk12), .rst_n(rst_n), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk12 = ~clk12;

  int n_checks = 0;
  int n_errs = 0;
  int cyc = 0;
  int last_err_cyc = 0;

  // scoreboard: expected writes {addr,data}, expected outcomes (0=done, else err code)
  logic [23:0] exp_q[$];
  logic [1:0]  evt_q[$];
  logic        model_hold = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_errs++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  function automatic logic [7:0] calc_csum(input logic [7:0] b[$]);
    logic [7:0] x = 8'h00;
    foreach (b[i]) x = x ^ b[i];
    return x;
  endfunction

  // compare against the model on every cycle
  task automatic compare_cycle();
    logic [23:0] e;
    logic [1:0]  ev;
    cyc++;
    check("cpu_hold", cpu_hold, model_hold);
    if (!rst_n) begin
      check("rst_mem_we", mem_we, 0);
      check("rst_pulses", {done, err}, 0);
    end else begin
      if (mem_we) begin
        if (exp_q.size() == 0) fail_now("unexpected_write", {mem_addr, mem_data});
        else begin
          e = exp_q.pop_front();
          check("write", {mem_addr, mem_data}, e);
        end
      end
      if (done && err) fail_now("done_and_err", {done, err});
      else if (done || err) begin
        if (err) last_err_cyc = cyc;
        if (evt_q.size() == 0) fail_now("unexpected_outcome", {done, err, err_code});
        else begin
          ev = evt_q.pop_front();
          check("outcome", done ? 2'd0 : err_code, ev);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk12);
    compare_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // driver: one strobe then one quiet cycle per byte; command byte updates cpu_hold model
  task automatic send_pkt(input logic [7:0] pkt[$]);
    for (int i = 0; i < pkt.size(); i++) begin
      rx_byte = pkt[i];
      rx_ready = 1'b1;
      if (i == 1 && pkt[0] == 8'hA5) begin
        if (pkt[1] == 8'h01 || pkt[1] == 8'h03) model_hold = 1'b1;
        else if (pkt[1] == 8'h02) model_hold = 1'b0;
      end
      step();
      rx_ready = 1'b0;
      step();
    end
  endtask

  // model: a WRITE packet produces LEN writes from base upward (wrapping) and one outcome
  task automatic expect_write(input logic [15:0] base, input logic [7:0] data[$], input logic good);
    for (int i = 0; i < data.size(); i++) exp_q.push_back({base + 16'(i), data[i]});
    evt_q.push_back(good ? 2'd0 : 2'd2);
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size() + evt_q.size(), 0);
  endtask

  initial begin
    logic [7:0] pkt[$];
    logic [7:0] dat[$];
    logic [7:0] hdr[$];
    int t0;
    int guard;

    idle(3);
    // 1: reset release
    rst_n = 1'b1;
    step();
    check("t1_cpu_hold", cpu_hold, 1);
    check("t1_busy", busy, 0);
    check("t1_mem_we", mem_we, 0);
    check("t1_err_code", err_code, 0);
    check("t1_addr_data", {mem_addr, mem_data}, 0);
    check("t1_state", state_dbg, 0);

    // model pins
    hdr = '{8'h01, 8'h00, 8'h80, 8'h02, 8'h12, 8'h34};
    check("csum_t2_literal", calc_csum(hdr), 8'hA5);

    // 2: two-byte write, checksum happens to equal SYNC
    dat = '{8'h12, 8'h34};
    expect_write(16'h8000, dat, 1'b1);
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h80, 8'h02, 8'h12, 8'h34, 8'hA5};
    send_pkt(pkt);
    idle(3);
    check_drained("t2_drained");
    check("t2_last_write", {mem_addr, mem_data}, 24'h8001_34);
    check("t2_err_code", err_code, 0);
    check("t2_busy", busy, 0);

    // 3: bad checksum, writes stay
    expect_write(16'h8000, dat, 1'b0);
    pkt[7] = 8'h00;
    send_pkt(pkt);
    idle(3);
    check_drained("t3_drained");
    check("t3_err_code", err_code, 2);
    check("t3_busy", busy, 0);

    // 4: 256-byte block wrapping the address space
    dat = {};
    for (int i = 0; i < 256; i++) dat.push_back(8'(i));
    hdr = '{8'h01, 8'hFF, 8'hFF, 8'h00};
    check("csum_t4_literal", calc_csum({hdr, dat}), 8'h01);
    expect_write(16'hFFFF, dat, 1'b1);
    pkt = {8'hA5, hdr, dat, calc_csum({hdr, dat})};
    send_pkt(pkt);
    idle(3);
    check_drained("t4_drained");
    check("t4_last_write", {mem_addr, mem_data}, 24'h00FE_FF);

    // 5: silence inside a packet
    evt_q.push_back(2'd3);
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h80};
    send_pkt(pkt);
    check("t5_busy_waiting", busy, 1);
    t0 = cyc;
    guard = 0;
    while (evt_q.size() != 0 && guard < 30000) begin
      step();
      guard++;
    end
    if (evt_q.size() != 0) begin
      fail_now("t5_timeout_never_fired", guard);
      evt_q.delete();
    end
    check("t5_window", ((last_err_cyc - t0) >= 23990) && ((last_err_cyc - t0) <= 24010), 1);
    idle(2);
    check("t5_err_code", err_code, 3);
    check("t5_busy", busy, 0);
    check("t5_hold_kept", cpu_hold, 1);
    evt_q.push_back(2'd0);
    send_pkt('{8'hA5, 8'h02});
    idle(2);
    check("t5_run", cpu_hold, 0);
    evt_q.push_back(2'd0);
    send_pkt('{8'hA5, 8'h03});
    idle(2);
    check("t5_hold", cpu_hold, 1);
    evt_q.push_back(2'd0);
    send_pkt('{8'hA5, 8'h02});
    idle(2);
    check_drained("t5_drained");

    // 6: bad command, stray byte, reset mid-data
    evt_q.push_back(2'd1);
    send_pkt('{8'hA5, 8'h07});
    idle(2);
    check("t6_err_code", err_code, 1);
    check("t6_hold_after_err", cpu_hold, 0);
    send_pkt('{8'h3C});
    idle(4);
    check("t6_stray_busy", busy, 0);
    check_drained("t6_stray_drained");
    check("t6_err_code_held", err_code, 1);
    exp_q.push_back(24'h1000_11);
    exp_q.push_back(24'h1001_22);
    send_pkt('{8'hA5, 8'h01, 8'h00, 8'h10, 8'h04, 8'h11, 8'h22});
    idle(2);
    check("t6_busy_mid", busy, 1);
    rst_n = 1'b0;
    model_hold = 1'b1;
    step();
    check("t6_rst_busy", busy, 0);
    check("t6_rst_outputs", {mem_addr, mem_data, err_code}, 0);
    rst_n = 1'b1;
    idle(3);
    check_drained("t6_partial_drained");
    dat = '{8'h5A};
    hdr = '{8'h01, 8'h34, 8'h12, 8'h01};
    check("csum_t6_literal", calc_csum({hdr, dat}), 8'h7C);
    expect_write(16'h1234, dat, 1'b1);
    send_pkt({8'hA5, hdr, dat, 8'h7C});
    idle(3);
    check_drained("t6_after_reset_drained");
    check("t6_after_reset_write", {mem_addr, mem_data}, 24'h1234_5A);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
